// File: rtl/md_pkg.sv
// Shared definitions for the HILO multiply/divide issue path: op encodings,
// controller states and default unit latencies.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MULU = 3'd0,
    OP_MUL  = 3'd1,
    OP_DIVU = 3'd2,
    OP_DIV  = 3'd3
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int CNT_W       = 4;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_DIV;
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Loadable 4-bit down-counter tracking the remaining busy cycles of the
// multiply/divide unit. zero_next flags that the next edge ends the run.
module md_lat_counter
  import md_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_next
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Saturate at zero so a stray decrement can never wrap the count.
  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  assign zero_next = dec & ~load & (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue controller for the HILO multiply/divide unit: launches ops, tracks
// their latency, stalls D-stage HI/LO users and flags bad requests.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_md_req,
  input  logic [2:0]  e_md_op,
  input  logic        e_mthi,
  input  logic        e_mtlo,
  input  logic [31:0] e_divisor,
  input  logic        d_md_use,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic        hi_write,
  output logic        lo_write,
  output logic        busy,
  output logic        stall_d,
  output logic        dz_flag,
  output logic        proto_err
);

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("md_issue_ctrl: MUL_LAT must be in 1..15");
  end
  if (DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_div_lat
    $error("md_issue_ctrl: DIV_LAT must be in 1..15");
  end

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT);

  md_state_e state_reg;
  md_state_e state_next;

  logic             op_legal;
  logic             div_by_zero;
  logic             launch;
  logic             run_done;
  logic [CNT_W-1:0] lat_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign op_legal    = op_is_legal(e_md_op);
  assign div_by_zero = op_is_div(e_md_op) && (e_divisor == 32'd0);
  assign lat_val     = op_is_div(e_md_op) ? DIV_LD : MUL_LD;

  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (e_md_req && op_legal && !div_by_zero) begin
          launch     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (run_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  md_lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (launch),
    .load_val (lat_val),
    .dec      (busy),
    .zero_next(run_done)
  );

  assign busy     = (state_reg == RUN);
  assign md_start = launch;
  assign md_op    = launch ? e_md_op : 3'd0;
  assign dz_flag  = ~busy & e_md_req & op_legal & div_by_zero;

  // An md request outranks mthi, which outranks mtlo; losers are dropped.
  assign hi_write = e_mthi & ~e_md_req & ~busy;
  assign lo_write = e_mtlo & ~e_mthi & ~e_md_req & ~busy;

  assign proto_err = (busy & (e_md_req | e_mthi | e_mtlo))
                   | (~busy & e_md_req & ~op_legal)
                   | (e_md_req & (e_mthi | e_mtlo))
                   | (e_mthi & e_mtlo);

  assign stall_d = d_md_use & (busy | launch);

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: an idle-state vector table for the
// combinational controls plus hand-written multi-cycle sequences.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_md_req;
  logic [2:0]  e_md_op;
  logic        e_mthi;
  logic        e_mtlo;
  logic [31:0] e_divisor;
  logic        d_md_use;
  logic        md_start;
  logic [2:0]  md_op;
  logic        hi_write;
  logic        lo_write;
  logic        busy;
  logic        stall_d;
  logic        dz_flag;
  logic        proto_err;

  int errors = 0;
  int checks = 0;

  md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .e_md_req (e_md_req),
    .e_md_op  (e_md_op),
    .e_mthi   (e_mthi),
    .e_mtlo   (e_mtlo),
    .e_divisor(e_divisor),
    .d_md_use (d_md_use),
    .md_start (md_start),
    .md_op    (md_op),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .busy     (busy),
    .stall_d  (stall_d),
    .dz_flag  (dz_flag),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [2:0]  op;
    logic        mthi;
    logic        mtlo;
    logic [31:0] dv;
    logic        du;
    logic        x_start;
    logic [2:0]  x_op;
    logic        x_hw;
    logic        x_lw;
    logic        x_stall;
    logic        x_dz;
    logic        x_perr;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    e_md_req  = 1'b0;
    e_md_op   = 3'd0;
    e_mthi    = 1'b0;
    e_mtlo    = 1'b0;
    e_divisor = 32'd0;
    d_md_use  = 1'b0;
  endtask

  // Launch one op with a D-stage HI/LO user held and count pulses over a window.
  task automatic run_op(input logic [2:0] op, input logic [31:0] dv, input int x_start,
                        input int x_busy, input int x_stall, input int x_dz, input string tag);
    int ns = 0, nb = 0, nst = 0, ndz = 0;
    logic [2:0] seen_op = 3'd0;
    @(posedge clk); #1;
    e_md_req = 1'b1; e_md_op = op; e_divisor = dv; d_md_use = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (md_start) begin ns++; seen_op = md_op; end
      nb  += int'(busy);
      nst += int'(stall_d);
      ndz += int'(dz_flag);
      @(posedge clk); #1;
      e_md_req = 1'b0;
    end
    d_md_use = 1'b0;
    $display("seq %s: starts=%0d busy=%0d stall=%0d dz=%0d", tag, ns, nb, nst, ndz);
    check({tag, " starts"}, ns, x_start);
    check({tag, " md_op"}, 32'(seen_op), (x_start != 0) ? 32'(op) : 32'd0);
    check({tag, " busy_cycles"}, nb, x_busy);
    check({tag, " stall_cycles"}, nst, x_stall);
    check({tag, " dz_pulses"}, ndz, x_dz);
  endtask

  initial begin
    //              req op  hi lo div        du  st  op  hw lw stl dz pe
    vecs[0]  = '{1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3'd2, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 3'd3, 1'b0, 1'b0, 32'd7, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 3'd5, 1'b0, 1'b0, 32'd9, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 3'd3, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 3'd7, 1'b0, 1'b0, 32'd4, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("reset: busy=%0b md_start=%0b stall_d=%0b", busy, md_start, stall_d);
    check("rst busy", 32'(busy), 32'd0);
    check("rst md_start", 32'(md_start), 32'd0);
    check("rst proto_err", 32'(proto_err), 32'd0);
    check("rst hi_lo_write", 32'({hi_write, lo_write}), 32'd0);
    reset = 1'b1;

    // Idle-state vectors: applied and checked within one cycle, cleared before the edge.
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      e_md_req = vecs[i].req; e_md_op = vecs[i].op; e_mthi = vecs[i].mthi;
      e_mtlo = vecs[i].mtlo; e_divisor = vecs[i].dv; d_md_use = vecs[i].du;
      @(negedge clk);
      $display("vec %0d: start=%0b op=%0d hw=%0b lw=%0b stall=%0b dz=%0b perr=%0b",
               i, md_start, md_op, hi_write, lo_write, stall_d, dz_flag, proto_err);
      check($sformatf("vec%0d md_start", i), 32'(md_start), 32'(vecs[i].x_start));
      check($sformatf("vec%0d md_op", i), 32'(md_op), 32'(vecs[i].x_op));
      check($sformatf("vec%0d hi_write", i), 32'(hi_write), 32'(vecs[i].x_hw));
      check($sformatf("vec%0d lo_write", i), 32'(lo_write), 32'(vecs[i].x_lw));
      check($sformatf("vec%0d stall_d", i), 32'(stall_d), 32'(vecs[i].x_stall));
      check($sformatf("vec%0d dz_flag", i), 32'(dz_flag), 32'(vecs[i].x_dz));
      check($sformatf("vec%0d proto_err", i), 32'(proto_err), 32'(vecs[i].x_perr));
      clear_inputs();
      @(negedge clk);
      check($sformatf("vec%0d busy_after", i), 32'(busy), 32'd0);
    end

    // Reset mid-RUN with cnt=3, then a normal MUL launch.
    @(posedge clk); #1;
    e_md_req = 1'b1; e_md_op = 3'd1; d_md_use = 1'b1;
    @(posedge clk); #1;
    e_md_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    $display("seq midrun_reset: busy=%0b stall_d=%0b", busy, stall_d);
    check("midrun_reset busy", 32'(busy), 32'd0);
    check("midrun_reset stall_d", 32'(stall_d), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    e_md_req = 1'b1; e_md_op = 3'd1;
    @(negedge clk);
    check("post_reset md_start", 32'(md_start), 32'd1);
    check("post_reset md_op", 32'(md_op), 32'd1);
    @(posedge clk); #1;
    e_md_req = 1'b0;
    @(negedge clk);
    check("post_reset busy", 32'(busy), 32'd1);
    d_md_use = 1'b0;
    repeat (8) @(posedge clk);

    run_op(3'd1, 32'd0, 1, 5, 6, 0, "mul");
    run_op(3'd3, 32'h0000_0007, 1, 10, 11, 0, "div");
    run_op(3'd2, 32'd0, 0, 0, 0, 1, "divu_zero");

    // Back-to-back MULU then DIVU: second launch on the first non-busy cycle.
    begin
      int nb = 0, start_idx = -1, last_busy = -1;
      logic launched2 = 1'b0;
      @(posedge clk); #1;
      e_md_req = 1'b1; e_md_op = 3'd0; e_divisor = 32'd3; d_md_use = 1'b1;
      for (int c = 0; c < 25; c++) begin
        @(negedge clk);
        if (md_start && c > 0) start_idx = c;
        if (busy) begin nb++; last_busy = c; end
        @(posedge clk); #1;
        e_md_req = 1'b0;
        if (!busy && !launched2) begin
          e_md_req = 1'b1; e_md_op = 3'd2; launched2 = 1'b1;
        end
      end
      clear_inputs();
      $display("seq b2b: second_start=%0d busy=%0d last_busy=%0d", start_idx, nb, last_busy);
      check("b2b second_start_cycle", start_idx, 6);
      check("b2b busy_total", nb, 15);
      check("b2b last_busy_cycle", last_busy, 16);
    end

    // mthi while busy (stall ignored), then mtlo while idle.
    @(posedge clk); #1;
    e_md_req = 1'b1; e_md_op = 3'd1;
    @(posedge clk); #1;
    e_md_req = 1'b0; e_mthi = 1'b1;
    @(negedge clk);
    $display("seq mthi_busy: hi_write=%0b proto_err=%0b", hi_write, proto_err);
    check("mthi_busy hi_write", 32'(hi_write), 32'd0);
    check("mthi_busy proto_err", 32'(proto_err), 32'd1);
    @(posedge clk); #1;
    e_mthi = 1'b0;
    repeat (6) @(posedge clk);
    #1 e_mtlo = 1'b1;
    @(negedge clk);
    $display("seq mtlo_idle: lo_write=%0b proto_err=%0b", lo_write, proto_err);
    check("mtlo_idle lo_write", 32'(lo_write), 32'd1);
    check("mtlo_idle proto_err", 32'(proto_err), 32'd0);
    @(posedge clk); #1;
    e_mtlo = 1'b0;
    @(negedge clk);
    check("mtlo_idle lo_write_drop", 32'(lo_write), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue controller for the HILO multiply/divide unit in the five-stage MIPS pipeline. It takes the E-stage mult/div/mthi/mtlo request and the D-stage "uses HI/LO" flag, then drives the unit's start, op, HI-write and LO-write controls. It tracks the operation latency itself and raises a D-stage stall while the unit is occupied. It also suppresses divide-by-zero launches and flags protocol violations.

## Interface
- `MUL_LAT`, 5: busy cycles after a MULU/MUL launch (1..15).
- `DIV_LAT`, 10: busy cycles after a DIVU/DIV launch (1..15).

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `e_md_req`  in  1  E-stage instruction is mult/multu/div/divu.
- `e_md_op`  in  3  op code: MULU=0, MUL=1, DIVU=2, DIV=3; 4..7 reserved.
- `e_mthi`  in  1  E-stage instruction is mthi.
- `e_mtlo`  in  1  E-stage instruction is mtlo.
- `e_divisor`  in  32  E-stage B operand, used for the zero check.
- `d_md_use`  in  1  D-stage instruction is any of mult/div/mfhi/mflo/mthi/mtlo.
- `md_start`  out  1  one-cycle launch pulse to the unit.
- `md_op`  out  3  op presented with `md_start`; 0 otherwise.
- `hi_write`  out  1  write HI from operand A.
- `lo_write`  out  1  write LO from operand A.
- `busy`  out  1  unit occupied (RUN state).
- `stall_d`  out  1  freeze PC/F/D and bubble E.
- `dz_flag`  out  1  one-cycle pulse: division by zero suppressed.
- `proto_err`  out  1  one-cycle pulse: request arrived while busy, or reserved op.

## Operation
- States:
  - IDLE: cnt=0.
  - RUN: cnt counts down from LAT.
- IDLE, `e_md_req`, op legal, not (op∈{DIVU,DIV} and `e_divisor`==0):
  - Combinational `md_start`=1 and `md_op`=`e_md_op` this cycle.
  - At the edge: cnt←MUL_LAT (op<2) or DIV_LAT, state←RUN.
- IDLE, `e_md_req`, divide with divisor 0:
  - No start; `dz_flag`=1 this cycle; state stays IDLE.
  - HI/LO keep their prior values.
- IDLE, `e_md_req`, op ≥4: no start; `proto_err`=1.
- RUN: cnt←cnt-1 each edge; when cnt==1 at an edge, state←IDLE, cnt←0.
- `hi_write` is combinational: `e_mthi & ~e_md_req & ~busy`. `lo_write` is the same with `e_mtlo`.
- Priority for simultaneous E flags: `e_md_req` > `e_mthi` > `e_mtlo`. The lower-priority flags are ignored and `proto_err`=1.
- Any E-stage request (`e_md_req`/`e_mthi`/`e_mtlo`) while `busy`:
  - Ignored; `proto_err`=1.
  - Cannot occur when `stall_d` is honoured.
- `stall_d` = `d_md_use & (busy | md_start)`, combinational.
- `busy` = (state==RUN), registered.

## Timing
- Reset (low, async): state IDLE, cnt 0. All registered outputs read 0; combinational outputs read 0 for an all-zero input.
- Release is synchronous to the next rising edge. No request is accepted on the edge where `reset` rises.
- Launch at edge N (`md_start` high in the cycle before N): `busy` is high from N through N+LAT-1 and low from N+LAT. Exactly LAT busy cycles.
- A D-stage HI/LO user behind a launch stalls LAT+1 cycles:
  - the launch cycle;
  - LAT busy cycles.
- It leaves D in the first cycle with `busy`=0.
- Back-to-back md ops: the second launches in the first cycle after `busy` falls. No idle gap is added.
- Reset asserted mid-RUN: immediate return to IDLE, `busy`=0, `stall_d` deasserts combinationally.
- cnt is a 4-bit counter and never wraps. Legal load values are 1..15; a parameter of 0 is rejected by an elaboration check.

## Structure
- Package `md_pkg`:
  - op encodings MULU/MUL/DIVU/DIV, shared with the HILO unit and the decoder;
  - state enum IDLE/RUN;
  - default MUL_LAT/DIV_LAT constants.
- One sub-module, `md_lat_counter`:
  - 4-bit loadable down-counter;
  - ports: load, load_val, dec enable, zero-next flag;
  - same async active-low reset.
- FSM, legality/zero checks and stall logic sit in the top module.

## Test plan
- Reset low mid-RUN (cnt=3) → `busy`=0 and `stall_d`=0 immediately; after release, a MUL launches normally.
- MUL (op=1), `d_md_use`=1 held:
  - `md_start` pulses once with `md_op`=1;
  - `busy` is high for exactly 5 cycles;
  - `stall_d` is high for 6 cycles.
- DIV with `e_divisor`=0x0000_0007 → 10 busy cycles. DIVU with `e_divisor`=0 → no `md_start`, `dz_flag` one pulse, `busy` stays 0.
- Back-to-back MULU then DIVU:
  - second `md_start` occurs on the first cycle `busy`=0;
  - total busy = 5+10 cycles with no gap.
- mthi while busy (stall bypassed by bench) → `hi_write`=0, `proto_err`=1. mtlo while idle → `lo_write`=1 for one cycle.
- `e_md_op`=5 while idle → no start, `proto_err`=1. `e_md_req` and `e_mthi` together → start only, `proto_err`=1.
